// File: rtl/game_seq_ctrl.sv
// game_seq_ctrl: frame-synchronous game sequencer producing frame tick, game state,
// ground scroll offset and per-frame flap pulses for the VGA pipeline.
module game_seq_ctrl #(
   parameter int SCROLL_STEP  = 2,
   parameter int SCREEN_W     = 1024,
   parameter int DEATH_FRAMES = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        left,
   input  logic        collision,
   output logic [1:0]  state,
   output logic [10:0] scroll_x,
   output logic        frame_tick,
   output logic        flap,
   output logic        score_clr,
   output logic        freeze
);
   localparam int CW = $clog2(DEATH_FRAMES + 1);
   typedef enum logic [1:0] {IDLE, PLAY, DEAD, WAIT_REL} state_t;
   state_t cur, nxt;
   logic vblnk_d, left_d, armed, press_pend, pend_nxt;
   logic tick, press, take, flap_nxt, clr_nxt;
   logic [CW-1:0] death_cnt, cnt_nxt;
   logic [10:0] scroll_nxt;
   logic [11:0] sum;
   assign state = cur;
   always_comb begin
      // armed blocks a tick until vblnk has been seen low after reset
      tick = vblnk & ~vblnk_d & armed;
      press = left & ~left_d;
      take = press_pend | press;
      sum = {1'b0, scroll_x} + 12'(SCROLL_STEP);
      nxt = cur;
      cnt_nxt = death_cnt;
      scroll_nxt = scroll_x;
      flap_nxt = 1'b0;
      clr_nxt = 1'b0;
      pend_nxt = tick ? 1'b0 : take;
      case (cur)
         IDLE: begin
            if (tick && take) begin
               nxt = PLAY;
               clr_nxt = 1'b1;
            end
         end
         PLAY: begin
            if (collision) begin
               nxt = DEAD;
               cnt_nxt = '0;
            end else if (tick) begin
               scroll_nxt = sum >= 12'(SCREEN_W) ? 11'(sum - 12'(SCREEN_W)) : sum[10:0];
               flap_nxt = take;
            end
         end
         DEAD: begin
            pend_nxt = 1'b0;
            if (tick) begin
               if (death_cnt == CW'(DEATH_FRAMES - 1)) nxt = WAIT_REL;
               else cnt_nxt = death_cnt + CW'(1);
            end
         end
         default: begin
            pend_nxt = 1'b0;
            if (tick && !left) begin
               nxt = IDLE;
               scroll_nxt = '0;
            end
         end
      endcase
      if (nxt != cur) pend_nxt = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cur        <= IDLE;
         scroll_x   <= '0;
         frame_tick <= 1'b0;
         flap       <= 1'b0;
         score_clr  <= 1'b0;
         freeze     <= 1'b1;
         vblnk_d    <= 1'b0;
         left_d     <= 1'b0;
         armed      <= 1'b0;
         press_pend <= 1'b0;
         death_cnt  <= '0;
      end else begin
         cur        <= nxt;
         scroll_x   <= scroll_nxt;
         frame_tick <= tick;
         flap       <= flap_nxt;
         score_clr  <= clr_nxt;
         freeze     <= nxt != PLAY;
         vblnk_d    <= vblnk;
         left_d     <= left;
         armed      <= armed | ~vblnk;
         press_pend <= pend_nxt;
         death_cnt  <= cnt_nxt;
      end
   end
endmodule

// File: doc/game_seq_ctrl.md
Name: game_seq_ctrl

Overview:
- Frame-synchronous game sequencer for the VGA pipeline.
- Derives a per-frame tick from vblnk and runs the IDLE/PLAY/DEAD/WAIT_REL game state machine.
- Generates the ground scroll offset consumed by the background drawer.
- Converts the raw "left" button into one flap pulse per frame. Sits beside the draw chain and feeds the drawing and bird blocks.

Parameters:
- SCROLL_STEP, 2, pixels added to scroll_x per frame in PLAY; must satisfy 0 < SCROLL_STEP < SCREEN_W.
- SCREEN_W, 1024, scroll wrap modulus in pixels.
- DEATH_FRAMES, 60, frames spent in DEAD before WAIT_REL; must be ≥ 1.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset
- vblnk  in  1  vertical blank, same clock domain as clk
- left  in  1  flap/start button level, already synchronised
- collision  in  1  level from collision detector, valid any cycle
- state  out  2  0=IDLE, 1=PLAY, 2=DEAD, 3=WAIT_REL
- scroll_x  out  11  ground/background horizontal offset, range 0..SCREEN_W-1
- frame_tick  out  1  one-cycle pulse per frame
- flap  out  1  one-cycle pulse, coincident with frame_tick
- score_clr  out  1  one-cycle pulse on IDLE→PLAY
- freeze  out  1  high when not in PLAY; motion blocks hold position

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - state=IDLE, scroll_x=0, frame_tick=0, flap=0, score_clr=0, freeze=1.
  - Internal vblnk_d=0, left_d=0, press_pend=0, death_cnt=0.
- All outputs are registered.
- Frame tick:
  - tick_int = vblnk & ~vblnk_d, a combinational term.
  - frame_tick is asserted the cycle after the edge where tick_int=1. Latency is 1 clk from vblnk rising; pulse width is exactly 1.
  - vblnk held high gives no further ticks.
- Press capture:
  - Any cycle with left & ~left_d sets press_pend.
  - press_pend is cleared when consumed at a tick.
  - A press arriving in the same cycle as tick_int is consumed by that tick.
  - Multiple presses within one frame give one flap.
  - press_pend is cleared on every state change.
- IDLE:
  - freeze=1; scroll_x holds.
  - On tick_int with press pending: go to PLAY; score_clr=1 with frame_tick; press consumed; no flap.
- PLAY:
  - freeze=0.
  - On tick_int: scroll_x ← (scroll_x+SCROLL_STEP) mod SCREEN_W. Wrap by subtraction when the sum is ≥ SCREEN_W.
  - On tick_int with press pending: flap=1 with frame_tick.
  - collision=1 in any cycle: next state DEAD and death_cnt ← 0. No tick qualification.
  - collision and tick_int in the same cycle: DEAD wins; scroll_x not advanced; no flap; frame_tick still pulses.
- DEAD:
  - freeze=1; scroll_x holds; presses ignored and not pended.
  - death_cnt increments per tick_int.
  - When death_cnt reaches DEATH_FRAMES-1 on a tick: go to WAIT_REL.
  - collision is ignored.
- WAIT_REL:
  - On tick_int with left=0: go to IDLE and set scroll_x ← 0.
  - With left=1 at a tick: stay in WAIT_REL.
  - Presses are not pended.
- Outputs freeze and state change in the cycle after the transition edge, consistent with frame_tick.
- Reset mid-frame or mid-state returns all values to reset on the next edge. The first tick after reset requires a fresh vblnk rising edge: if vblnk=1 during reset, no tick occurs until it falls and rises.
- Widths: scroll_x is 11 bits. The internal sum is 12 bits to avoid overflow before the wrap compare. death_cnt uses $clog2(DEATH_FRAMES+1) bits.

Test Plan:
- Reset with vblnk=1, release reset, hold vblnk=1 for 100 cycles, then drop and re-raise it → no frame_tick until the re-rise; then exactly one 1-cycle pulse, 1 clk after the rise.
- IDLE: press left mid-frame → at next tick state=1, score_clr=1, flap=0, scroll_x=0. After 3 more ticks scroll_x=6.
- PLAY with scroll_x=1022, STEP=2, SCREEN_W=1024: one tick → scroll_x=0. Three presses within one frame → exactly one flap pulse, at the next tick.
- PLAY: collision asserted in the same cycle as tick_int, scroll_x=100 → state=2, scroll_x stays 100, flap=0, frame_tick=1.
- DEAD with DEATH_FRAMES=60 and left toggling → state=2 for 59 ticks and state=3 after tick 60; no flap pulses.
- WAIT_REL with left held at 1 across 5 ticks → stays 3. Release left, then next tick → state=0, scroll_x=0, freeze=1.
